seq_det_sched: RTL and testbench

- Controller that sequences a serial Moore sequence detector (1-bit input, 1-bit registered output) over a parallel test word.
- On start it resets the detector, shifts the word in LSB-first at one bit per clock, and samples the detector output with its one-cycle Moore latency accounted for.
- Reports hit count and first-hit bit index with a start/busy/done handshake.
- Sits between a host or bench stimulus source and the detector instance, replacing hand-timed bench stimulus loops.

---
 rtl/seq_det_sched.sv | 126 ++++++++++++
 tb/tb_seq_det_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// Sequences a serial Moore detector over a parallel test word, shifting LSB-first,
// and reports the hit count and first-hit bit index through a start/busy/done handshake.
module seq_det_sched #(
  parameter int WIDTH = 60,
  parameter int IDXW  = 6,
  parameter int CNTW  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  pattern,
  output logic              det_reset_n,
  output logic              det_i,
  input  logic              det_o,
  output logic              busy,
  output logic              done,
  output logic [CNTW-1:0]   hit_cnt,
  output logic              first_hit_vld,
  output logic [IDXW-1:0]   first_hit_idx
);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IDXW-1:0]  bit_idx;
  logic             sample_en;
  logic [IDXW-1:0]  sample_idx;
  logic             abort_run;

  // det_o lags det_i by one cycle, so the sample taken in SHIFT k belongs to bit k-1
  // and the DRAIN sample belongs to the last bit.
  always_comb begin
    sample_en  = 1'b0;
    sample_idx = '0;
    abort_run  = abort && (state == CLR || state == SHIFT || state == DRAIN);
    if (state == SHIFT && bit_idx != '0) begin
      sample_en  = 1'b1;
      sample_idx = bit_idx - IDXW'(1);
    end else if (state == DRAIN) begin
      sample_en  = 1'b1;
      sample_idx = bit_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_idx       <= '0;
      det_reset_n   <= 1'b0;
      det_i         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hit_cnt       <= '0;
      first_hit_vld <= 1'b0;
      first_hit_idx <= '0;
    end else if (abort_run) begin
      // Pulse the detector reset on the way out so no stale state survives the abort.
      state       <= IDLE;
      det_reset_n <= 1'b0;
      det_i       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sample_en && det_o) begin
        if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNTW'(1);
        if (!first_hit_vld) begin
          first_hit_vld <= 1'b1;
          first_hit_idx <= sample_idx;
        end
      end
      case (state)
        IDLE: begin
          det_reset_n <= 1'b1;
          det_i       <= 1'b0;
          if (start) begin
            state         <= CLR;
            busy          <= 1'b1;
            det_reset_n   <= 1'b0;
            shreg         <= pattern;
            bit_idx       <= '0;
            hit_cnt       <= '0;
            first_hit_vld <= 1'b0;
            first_hit_idx <= '0;
          end
        end
        CLR: begin
          state       <= SHIFT;
          det_reset_n <= 1'b1;
          det_i       <= shreg[0];
          shreg       <= shreg >> 1;
          bit_idx     <= '0;
        end
        SHIFT: begin
          if (bit_idx == LAST_IDX) begin
            state <= DRAIN;
            det_i <= 1'b0;
          end else begin
            det_i   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + IDXW'(1);
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench: two WIDTH=8 schedulers (normal and CNTW=2) each driving a stub
// detector whose output is its registered input.
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;

  logic       det_reset_n, det_i, busy, done, first_hit_vld;
  logic [6:0] hit_cnt;
  logic [5:0] first_hit_idx;
  logic       stub_q;

  logic       s_det_reset_n, s_det_i, s_busy, s_done, s_first_hit_vld;
  logic [1:0] s_hit_cnt;
  logic [5:0] s_first_hit_idx;
  logic       s_stub_q;

  int checks = 0;
  int passes = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  seq_det_sched #(.WIDTH(8), .IDXW(6), .CNTW(7)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .det_reset_n(det_reset_n), .det_i(det_i), .det_o(stub_q),
    .busy(busy), .done(done), .hit_cnt(hit_cnt),
    .first_hit_vld(first_hit_vld), .first_hit_idx(first_hit_idx)
  );

  seq_det_sched #(.WIDTH(8), .IDXW(6), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .det_reset_n(s_det_reset_n), .det_i(s_det_i), .det_o(s_stub_q),
    .busy(s_busy), .done(s_done), .hit_cnt(s_hit_cnt),
    .first_hit_vld(s_first_hit_vld), .first_hit_idx(s_first_hit_idx)
  );

  always_ff @(posedge clk) begin
    stub_q   <= det_reset_n ? det_i : 1'b0;
    s_stub_q <= s_det_reset_n ? s_det_i : 1'b0;
  end

  always @(negedge clk) if (done) done_count++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // One full run; optionally pokes start mid-SHIFT and during DONE, which must be ignored.
  task automatic applyStimulus(input logic [7:0] pat, input logic [6:0] exp_cnt,
                               input logic exp_vld, input logic [5:0] exp_idx,
                               input logic [1:0] exp_sat, input bit poke);
    int d0;
    d0 = done_count;
    start = 1'b1;
    pattern = pat;
    step();
    start = 1'b0;
    pattern = ~pat;
    checkOutput("clr_busy", busy, 1);
    checkOutput("clr_det_reset_n", det_reset_n, 0);
    for (int i = 0; i < 8; i++) begin
      start = (poke && i == 3);
      step();
      checkOutput($sformatf("det_i[%0d]", i), det_i, pat[i]);
      checkOutput($sformatf("shift_rstn[%0d]", i), det_reset_n, 1);
    end
    start = 1'b0;
    step();
    checkOutput("drain_done", done, 0);
    checkOutput("drain_det_i", det_i, 0);
    step();
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 1);
    checkOutput("hit_cnt", hit_cnt, exp_cnt);
    checkOutput("first_hit_vld", first_hit_vld, exp_vld);
    checkOutput("first_hit_idx", first_hit_idx, exp_idx);
    checkOutput("sat_hit_cnt", s_hit_cnt, exp_sat);
    start = poke;
    step();
    start = 1'b0;
    checkOutput("idle_done", done, 0);
    checkOutput("idle_busy", busy, 0);
    if (poke) begin
      step();
      step();
      checkOutput("poke_still_idle", busy, 0);
      checkOutput("poke_hit_cnt_held", hit_cnt, exp_cnt);
      checkOutput("poke_first_idx_held", first_hit_idx, exp_idx);
    end
    #2;
    checkOutput("done_once", done_count - d0, 1);
  endtask

  initial begin
    int d0;
    $display("[TB] seq_det_sched directed test");
    step();
    step();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_det_reset_n", det_reset_n, 0);
    checkOutput("rst_hit_cnt", hit_cnt, 0);
    checkOutput("rst_first_vld", first_hit_vld, 0);
    reset = 1'b0;
    step();
    checkOutput("idle_det_reset_n", det_reset_n, 1);

    applyStimulus(8'b1010_0110, 7'd4, 1'b1, 6'd1, 2'd3, 1'b0);
    applyStimulus(8'h00, 7'd0, 1'b0, 6'd0, 2'd0, 1'b0);
    applyStimulus(8'hFF, 7'd8, 1'b1, 6'd0, 2'd3, 1'b0);
    checkOutput("sat_first_idx", s_first_hit_idx, 0);
    applyStimulus(8'b0100_1000, 7'd2, 1'b1, 6'd3, 2'd2, 1'b1);

    // Abort at SHIFT k=3 (cycle 5 after the start edge).
    d0 = done_count;
    start = 1'b1;
    pattern = 8'hFF;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_det_reset_n", det_reset_n, 0);
    checkOutput("abort_det_i", det_i, 0);
    step();
    checkOutput("abort_rstn_back", det_reset_n, 1);
    for (int i = 0; i < 8; i++) step();
    checkOutput("abort_no_done", done_count - d0, 0);
    applyStimulus(8'b1010_0110, 7'd4, 1'b1, 6'd1, 2'd3, 1'b0);

    // Reset together with start mid-SHIFT.
    start = 1'b1;
    pattern = 8'hFF;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_det_reset_n", det_reset_n, 0);
    checkOutput("mrst_hit_cnt", hit_cnt, 0);
    checkOutput("mrst_first_vld", first_hit_vld, 0);
    checkOutput("mrst_det_i", det_i, 0);
    step();
    checkOutput("mrst_idle_busy", busy, 0);
    applyStimulus(8'b1000_0000, 7'd1, 1'b1, 6'd7, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
